// File: rtl/booth_pkg.sv
// Shared definitions for the Booth dot-product accumulator slice.
//   PROD_W   : width of the signed products produced by the 2-bit Booth multiplier
//   state_e  : accumulator FSM states (IDLE, ACCUM, DONE)
//   sat_max / sat_min : largest / smallest two's-complement value at a given width
package booth_pkg;

  localparam int PROD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational accumulate step: acc + sext(product), evaluated one bit wider
// than the accumulator so that overflow is detected exactly.
//   acc_i  : current signed accumulator value (ACC_W bits)
//   prod_i : signed product (PROD_W bits)
//   sum_o  : next accumulator value (ACC_W bits)
//   ovf_o  : true sum does not fit the signed ACC_W range
// Build option: SATURATE_EN defined clamps sum_o to the signed range on
// overflow; otherwise sum_o keeps the low ACC_W bits (modulo wrap).
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic signed [ACC_W:0] full;

  assign full  = $signed({acc_i[ACC_W-1], acc_i})
               + $signed({{(ACC_W + 1 - PROD_W){prod_i[PROD_W-1]}}, prod_i});

  // The wide sum fits in ACC_W bits only when its top two bits agree.
  assign ovf_o = full[ACC_W] ^ full[ACC_W-1];

`ifdef SATURATE_EN
  localparam logic [ACC_W-1:0] SMAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] SMIN = ACC_W'(sat_min(ACC_W));

  // The sign of the wide sum tells which rail was crossed.
  assign sum_o = ovf_o ? (full[ACC_W] ? SMIN : SMAX) : full[ACC_W-1:0];
`else
  assign sum_o = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/booth_dot_accumulator.sv
// Sums runs of LEN signed Booth products into one dot-product result and
// presents it through a valid/ready output register.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous abort of any partial or held result
//   in_valid/in_ready     : product input handshake, in_product is 4-bit signed
//   out_valid/out_ready   : result handshake
//   out_sum               : signed ACC_W-bit result, out_ovf: overflow seen
// Build option: SATURATE_EN selects clamping instead of modulo wrap on overflow.
// Every output is a register or a decode of the state register.
module booth_dot_accumulator
  import booth_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int LEN   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = $clog2(LEN + 1);
  // Count value at which the next accepted beat completes the run.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             beat;

  booth_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i  (acc_q),
    .prod_i (in_product),
    .sum_o  (add_sum),
    .ovf_o  (add_ovf)
  );

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

  assign beat = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (flush) begin
      // Abort wins over any beat or output handshake in the same cycle.
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (beat) begin
            // First product of a run cannot overflow since ACC_W >= PROD_W.
            acc_d   = ACC_W'($signed(in_product));
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            state_d = (LEN == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_d = add_sum;
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | add_ovf;
            if (cnt_q == CNT_LAST) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
